// File: rtl/nvme_io_scheduler.sv
// NVMe command-slot allocator, CQ consumer and SQ/CQ doorbell arbiter for one I/O queue pair.
// Grants and completions are registered (1 cycle); one doorbell in flight, later updates coalesce.
module nvme_io_scheduler #(
    parameter int          OUTSTANDING = 16,
    parameter int          CID_W       = 4,
    parameter int          QID         = 1,
    parameter logic [31:0] DB_BASE     = 32'h0000_1000,
    parameter int          DSTRD       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [CID_W-1:0] alloc_cid,
    output logic [CID_W-1:0] sq_cid,
    input  logic             cmd_written,
    output logic             db_valid,
    input  logic             db_ready,
    output logic [31:0]      db_addr,
    output logic [31:0]      db_data,
    input  logic             db_done,
    input  logic             cqe_valid,
    output logic             cqe_ready,
    input  logic [15:0]      cqe_cid,
    input  logic             cqe_phase,
    input  logic [14:0]      cqe_status,
    output logic             cpl_valid,
    output logic [CID_W-1:0] cpl_cid,
    output logic [14:0]      cpl_status,
    output logic             cpl_err,
    output logic [CID_W:0]   inflight,
    output logic [15:0]      stale_cnt
);

    localparam logic [31:0]    SQ_DB_ADDR   = DB_BASE + 32'((2 * QID) * (4 << DSTRD));
    localparam logic [31:0]    CQ_DB_ADDR   = DB_BASE + 32'((2 * QID + 1) * (4 << DSTRD));
    localparam logic [CID_W:0] MAX_INFLIGHT = (CID_W + 1)'(OUTSTANDING - 1);

    typedef enum logic [1:0] {DB_IDLE, DB_REQ, DB_RESP} db_state_t;

    db_state_t              db_state, db_next;
    logic [OUTSTANDING-1:0] free_map, free_nxt;
    logic [CID_W-1:0]       sq_tail, sq_tail_rung, sq_tail_written;
    logic [CID_W-1:0]       cq_head, cq_head_rung;
    logic [CID_W:0]         pending_written;
    logic                   exp_phase;
    logic                   last_served_cq;

    logic [CID_W-1:0]       free_idx;
    logic                   free_any;
    logic                   grant;
    logic [CID_W-1:0]       cqe_slot;
    logic                   cid_hi_ok, slot_busy, accept, retire;
    logic                   sq_pend, cq_pend, serve_sq, serve_cq;

    // Priority encoder: lowest-index free slot wins.
    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        for (int i = OUTSTANDING - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                free_idx = CID_W'(i);
                free_any = 1'b1;
            end
        end
    end

    assign grant     = alloc_req && !alloc_gnt && (inflight < MAX_INFLIGHT) && free_any;
    assign cqe_slot  = cqe_cid[CID_W-1:0];
    assign cid_hi_ok = (cqe_cid[15:CID_W] == '0);
    assign slot_busy = !free_map[cqe_slot];
    assign accept    = cqe_valid && (cqe_phase == exp_phase);
    assign retire    = accept && cid_hi_ok && slot_busy;

    // Grant picks from the pre-update bitmap, so a slot freed this cycle is never reissued this cycle.
    always_comb begin
        free_nxt = free_map;
        if (retire) free_nxt[cqe_slot] = 1'b1;
        if (grant)  free_nxt[free_idx] = 1'b0;
    end

    assign sq_tail_written = sq_tail_rung + pending_written[CID_W-1:0];
    assign sq_pend         = (sq_tail_written != sq_tail_rung);
    assign cq_pend         = (cq_head != cq_head_rung);
    assign db_valid        = (db_state == DB_REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) db_state <= DB_IDLE;
        else     db_state <= db_next;
    end

    always_comb begin
        db_next  = db_state;
        serve_sq = 1'b0;
        serve_cq = 1'b0;
        case (db_state)
            DB_IDLE: begin
                if (sq_pend && (!cq_pend || last_served_cq)) serve_sq = 1'b1;
                else if (cq_pend)                            serve_cq = 1'b1;
                if (serve_sq || serve_cq) db_next = DB_REQ;
            end
            DB_REQ:  if (db_ready) db_next = DB_RESP;
            DB_RESP: if (db_done)  db_next = DB_IDLE;
            default: db_next = DB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cqe_ready       <= 1'b0;
            free_map        <= '1;
            inflight        <= '0;
            alloc_gnt       <= 1'b0;
            alloc_cid       <= '0;
            sq_cid          <= '0;
            sq_tail         <= '0;
            sq_tail_rung    <= '0;
            pending_written <= '0;
            cq_head         <= '0;
            cq_head_rung    <= '0;
            exp_phase       <= 1'b1;
            last_served_cq  <= 1'b1;
            stale_cnt       <= '0;
            cpl_valid       <= 1'b0;
            cpl_cid         <= '0;
            cpl_status      <= '0;
            cpl_err         <= 1'b0;
            db_addr         <= '0;
            db_data         <= '0;
        end else begin
            cqe_ready <= 1'b1;
            free_map  <= free_nxt;
            alloc_gnt <= grant;
            if (grant) begin
                alloc_cid <= free_idx;
                sq_cid    <= sq_tail;
                sq_tail   <= sq_tail + 1'b1;
            end
            if (grant && !retire)      inflight <= inflight + 1'b1;
            else if (!grant && retire) inflight <= inflight - 1'b1;

            // Latching the doorbell covers everything written so far; a same-cycle write stays pending.
            if (serve_sq)         pending_written <= (CID_W + 1)'(cmd_written);
            else if (cmd_written) pending_written <= pending_written + 1'b1;

            if (cqe_valid && !accept && stale_cnt != '1) stale_cnt <= stale_cnt + 1'b1;
            cpl_valid <= accept;
            if (accept) begin
                cq_head    <= cq_head + 1'b1;
                if (cq_head == '1) exp_phase <= ~exp_phase;
                cpl_cid    <= cqe_slot;
                cpl_status <= cqe_status;
                cpl_err    <= (cqe_status != '0) || !cid_hi_ok || !slot_busy;
            end

            if (serve_sq) begin
                db_addr        <= SQ_DB_ADDR;
                db_data        <= 32'(sq_tail_written);
                sq_tail_rung   <= sq_tail_written;
                last_served_cq <= 1'b0;
            end else if (serve_cq) begin
                db_addr        <= CQ_DB_ADDR;
                db_data        <= 32'(cq_head);
                cq_head_rung   <= cq_head;
                last_served_cq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nvme_io_scheduler.sv
// Directed bench for nvme_io_scheduler: allocation, completion, stale CQEs, doorbell coalescing and SQ/CQ alternation.
module tb_nvme_io_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req, alloc_gnt;
    logic [3:0]  alloc_cid, sq_cid;
    logic        cmd_written;
    logic        db_valid, db_ready, db_done;
    logic [31:0] db_addr, db_data;
    logic        cqe_valid, cqe_ready, cqe_phase;
    logic [15:0] cqe_cid;
    logic [14:0] cqe_status;
    logic        cpl_valid, cpl_err;
    logic [3:0]  cpl_cid;
    logic [14:0] cpl_status;
    logic [4:0]  inflight;
    logic [15:0] stale_cnt;

    int n_cmp = 0;
    int n_err = 0;

    nvme_io_scheduler dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_cid(alloc_cid), .sq_cid(sq_cid),
        .cmd_written(cmd_written),
        .db_valid(db_valid), .db_ready(db_ready), .db_addr(db_addr), .db_data(db_data), .db_done(db_done),
        .cqe_valid(cqe_valid), .cqe_ready(cqe_ready), .cqe_cid(cqe_cid), .cqe_phase(cqe_phase),
        .cqe_status(cqe_status),
        .cpl_valid(cpl_valid), .cpl_cid(cpl_cid), .cpl_status(cpl_status), .cpl_err(cpl_err),
        .inflight(inflight), .stale_cnt(stale_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_db(input string tag);
        int k = 0;
        while (db_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(db_valid), 32'd1);
    endtask

    task automatic db_finish();
        db_ready = 1'b1;
        tick();
        db_ready = 1'b0;
        chk("db_valid_drop", 32'(db_valid), 32'd0);
        db_done = 1'b1;
        tick();
        db_done = 1'b0;
    endtask

    task automatic send_cqe(input logic [15:0] cid, input logic ph, input logic [14:0] st);
        cqe_valid  = 1'b1;
        cqe_cid    = cid;
        cqe_phase  = ph;
        cqe_status = st;
        tick();
        cqe_valid  = 1'b0;
    endtask

    task automatic inject_both();
        cmd_written = 1'b1;
        send_cqe(16'd9, 1'b0, 15'd0);
        cmd_written = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr [9];
        logic [31:0] exp_data [9];
        int ngr;
        int k;

        exp_addr = '{32'h1008, 32'h100C, 32'h1008, 32'h100C, 32'h1008, 32'h100C, 32'h1008, 32'h100C, 32'h1008};
        exp_data = '{32'd5, 32'd3, 32'd7, 32'd5, 32'd9, 32'd7, 32'd11, 32'd9, 32'd12};

        rst = 1'b1;
        alloc_req = 1'b0; cmd_written = 1'b0; db_ready = 1'b0; db_done = 1'b0;
        cqe_valid = 1'b0; cqe_cid = '0; cqe_phase = 1'b0; cqe_status = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cqe_ready", 32'(cqe_ready), 32'd0);
        chk("rst_alloc_gnt", 32'(alloc_gnt), 32'd0);
        chk("rst_db_valid", 32'(db_valid), 32'd0);
        chk("rst_cpl_valid", 32'(cpl_valid), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_stale", 32'(stale_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("cqe_ready_up", 32'(cqe_ready), 32'd1);

        // First allocation and its SQ doorbell
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        chk("t1_gnt", 32'(alloc_gnt), 32'd1);
        chk("t1_cid", 32'(alloc_cid), 32'd0);
        chk("t1_sq_cid", 32'(sq_cid), 32'd0);
        chk("t1_inflight", 32'(inflight), 32'd1);
        tick();
        chk("t1_gnt_pulse", 32'(alloc_gnt), 32'd0);
        cmd_written = 1'b1;
        tick();
        cmd_written = 1'b0;
        wait_db("t1_db_wait");
        chk("t1_db_addr", db_addr, 32'h1008);
        chk("t1_db_data", db_data, 32'd1);
        db_finish();
        chk("t1_inflight_after", 32'(inflight), 32'd1);

        // Completion of cid 0 and its CQ doorbell
        send_cqe(16'd0, 1'b1, 15'd0);
        chk("t2_cpl_valid", 32'(cpl_valid), 32'd1);
        chk("t2_cpl_cid", 32'(cpl_cid), 32'd0);
        chk("t2_cpl_err", 32'(cpl_err), 32'd0);
        chk("t2_inflight", 32'(inflight), 32'd0);
        tick();
        chk("t2_cpl_pulse", 32'(cpl_valid), 32'd0);
        wait_db("t2_db_wait");
        chk("t2_db_addr", db_addr, 32'h100C);
        chk("t2_db_data", db_data, 32'd1);
        db_finish();

        // Held request fills the queue to depth-1
        ngr = 0;
        alloc_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (alloc_gnt === 1'b1) begin
                chk("t3_cid", 32'(alloc_cid), 32'(ngr));
                chk("t3_sq_cid", 32'(sq_cid), 32'((1 + ngr) % 16));
                ngr++;
            end
        end
        chk("t3_grant_count", 32'(ngr), 32'd15);
        chk("t3_inflight_full", 32'(inflight), 32'd15);
        send_cqe(16'd7, 1'b1, 15'd0);
        chk("t3_cpl_cid7", 32'(cpl_cid), 32'd7);
        chk("t3_cpl_err7", 32'(cpl_err), 32'd0);
        chk("t3_no_gnt_yet", 32'(alloc_gnt), 32'd0);
        k = 0;
        while (alloc_gnt !== 1'b1 && k < 5) begin
            tick();
            k++;
        end
        alloc_req = 1'b0;
        chk("t3_regrant", 32'(alloc_gnt), 32'd1);
        chk("t3_regrant_cid", 32'(alloc_cid), 32'd7);
        chk("t3_regrant_sq", 32'(sq_cid), 32'd0);
        chk("t3_inflight_15", 32'(inflight), 32'd15);

        // Three writes land during the CQ doorbell's response wait, then coalesce
        wait_db("t4_cq_wait");
        chk("t4_cq_addr", db_addr, 32'h100C);
        chk("t4_cq_data", db_data, 32'd2);
        db_ready = 1'b1;
        tick();
        db_ready = 1'b0;
        cmd_written = 1'b1;
        repeat (3) tick();
        cmd_written = 1'b0;
        chk("t4_resp_hold", 32'(db_valid), 32'd0);
        db_done = 1'b1;
        tick();
        db_done = 1'b0;
        wait_db("t4_sq_wait");
        chk("t4_sq_addr", db_addr, 32'h1008);
        chk("t4_sq_data", db_data, 32'd4);
        db_finish();

        // CQ wrap, stale phase, phase flip
        for (int i = 0; i < 14; i++) begin
            send_cqe(16'(i), 1'b1, 15'd0);
            chk("t5_cpl_cid", 32'(cpl_cid), 32'(i));
            chk("t5_cpl_err", 32'(cpl_err), 32'd0);
        end
        chk("t5_inflight", 32'(inflight), 32'd1);
        send_cqe(16'd14, 1'b1, 15'd0);
        chk("t5_stale_cnt", 32'(stale_cnt), 32'd1);
        chk("t5_stale_no_cpl", 32'(cpl_valid), 32'd0);
        send_cqe(16'd14, 1'b0, 15'd2);
        chk("t5_wrap_cpl", 32'(cpl_valid), 32'd1);
        chk("t5_wrap_cid", 32'(cpl_cid), 32'd14);
        chk("t5_wrap_status", 32'(cpl_status), 32'd2);
        chk("t5_wrap_err", 32'(cpl_err), 32'd1);
        chk("t5_inflight0", 32'(inflight), 32'd0);
        wait_db("t5_db1_wait");
        chk("t5_db1_addr", db_addr, 32'h100C);
        db_finish();
        wait_db("t5_db2_wait");
        chk("t5_db2_addr", db_addr, 32'h100C);
        chk("t5_db2_data", db_data, 32'd1);
        db_finish();

        // SQ and CQ both pending at every idle point
        inject_both();
        chk("t6_bad_cid_err", 32'(cpl_err), 32'd1);
        chk("t6_bad_cid", 32'(cpl_cid), 32'd9);
        chk("t6_inflight", 32'(inflight), 32'd0);
        for (int d = 0; d < 9; d++) begin
            wait_db("t6_db_wait");
            chk("t6_db_addr", db_addr, exp_addr[d]);
            chk("t6_db_data", db_data, exp_data[d]);
            db_ready = 1'b1;
            tick();
            db_ready = 1'b0;
            if (d < 7) inject_both();
            db_done = 1'b1;
            tick();
            db_done = 1'b0;
        end
        repeat (3) tick();
        chk("t6_idle", 32'(db_valid), 32'd0);
        chk("t6_inflight_end", 32'(inflight), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
